// File: rtl/mv_pattern_gen.sv
// mv_pattern_gen: programmable-timing video test pattern generator.
// Ports:
//   clk, rst_n                       pixel clock, async active-low reset
//   mode, auto_cycle                 requested pattern / automatic pattern stepping
//   solid_rgb                        {r,g,b} colour for the solid pattern
//   positive_hsync, positive_vsync   sync polarity (1 = active-high)
//   h*/v* timing                     totals, active window and sync window
//   hs, vs, de, rgb_r/g/b            video output, 2 clocks behind the counters
//   active_mode                      pattern currently displayed
//   frame_start                      pulse with the first output cycle of a frame
module mv_pattern_gen #(
   parameter int DATA_W      = 8,
   parameter int CHK_LOG2    = 5,
   parameter int AUTO_FRAMES = 60
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            mode,
   input  logic                  auto_cycle,
   input  logic [3*DATA_W-1:0]   solid_rgb,
   input  logic                  positive_hsync,
   input  logic                  positive_vsync,
   input  logic [15:0]           htotal_size,
   input  logic [15:0]           hactive_start,
   input  logic [15:0]           hactive_end,
   input  logic [15:0]           hsync_start,
   input  logic [15:0]           hsync_end,
   input  logic [15:0]           vtotal_size,
   input  logic [15:0]           vactive_start,
   input  logic [15:0]           vactive_end,
   input  logic [15:0]           vsync_start,
   input  logic [15:0]           vsync_end,
   output logic                  hs,
   output logic                  vs,
   output logic                  de,
   output logic [DATA_W-1:0]     rgb_r,
   output logic [DATA_W-1:0]     rgb_g,
   output logic [DATA_W-1:0]     rgb_b,
   output logic [2:0]            active_mode,
   output logic                  frame_start
);
   localparam int RGB_W = 3 * DATA_W;

   logic [15:0]      h_q, h_d, v_q, v_d, fc_q, fc_d;
   logic [2:0]       mode_q, mode_d;
   logic [RGB_W-1:0] solid_q, solid_d;
   logic             fs0_q, fs0_d;
   logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
   logic [RGB_W-1:0] rgb1_q, rgb1_d, rgb_q, rgb_d;
   logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

   logic             deg, h_wrap, v_wrap, bnd, fc_done, border;
   logic [15:0]      x, y, hact, vact, w;
   logic [2:0]       bar, next_mode;

   always_comb begin
      // Degenerate totals park the counters at the origin and blank the picture
      deg     = (htotal_size < 16'd2) || (vtotal_size < 16'd2);
      // >= so a shrinking total mid-frame still wraps instead of running away
      h_wrap  = h_q >= htotal_size - 16'd1;
      v_wrap  = v_q >= vtotal_size - 16'd1;
      bnd     = !deg && h_wrap && v_wrap;
      h_d     = (deg || h_wrap) ? '0 : h_q + 16'd1;
      v_d     = deg ? '0 : h_wrap ? (v_wrap ? '0 : v_q + 16'd1) : v_q;
      // fs0 marks the first pixel of a frame that followed a real boundary
      fs0_d   = bnd;
      solid_d = bnd ? solid_rgb : solid_q;
      fc_done = fc_q >= 16'(AUTO_FRAMES - 1);
      fc_d    = !auto_cycle ? '0 : !bnd ? fc_q : fc_done ? '0 : fc_q + 16'd1;
      next_mode = auto_cycle ? (fc_done ? ((mode_q >= 3'd5) ? 3'd0 : mode_q + 3'd1) : mode_q)
                             : ((mode > 3'd5) ? 3'd0 : mode);
      mode_d  = bnd ? next_mode : mode_q;
      x       = h_q - hactive_start;
      y       = v_q - vactive_start;
      hact    = hactive_end - hactive_start;
      vact    = vactive_end - vactive_start;
      w       = hact >> 3;
      // Bar index = number of bar edges already passed; saturates at 7
      bar     = '0;
      for (int k = 1; k < 8; k++)
         bar = bar + {2'b0, x >= w * 16'(k)};
      border  = (x == 16'd0) || (x == hact - 16'd1) || (y == 16'd0) || (y == vact - 16'd1);
      case (mode_q)
         3'd0:    rgb1_d = {{DATA_W{~bar[1]}}, {DATA_W{~bar[2]}}, {DATA_W{~bar[0]}}};
         3'd1:    rgb1_d = {3{x[DATA_W-1:0]}};
         3'd2:    rgb1_d = {3{y[DATA_W-1:0]}};
         3'd3:    rgb1_d = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? '0 : '1;
         3'd4:    rgb1_d = solid_q;
         3'd5:    rgb1_d = border ? '1 : '0;
         default: rgb1_d = '0;
      endcase
      de1_d   = !deg && (h_q >= hactive_start) && (h_q < hactive_end)
                     && (v_q >= vactive_start) && (v_q < vactive_end);
      hs1_d   = ((h_q >= hsync_start) && (h_q < hsync_end)) == positive_hsync;
      vs1_d   = ((v_q >= vsync_start) && (v_q < vsync_end)) == positive_vsync;
      fs1_d   = fs0_q;
      de_d    = de1_q;
      hs_d    = hs1_q;
      vs_d    = vs1_q;
      fs_d    = fs1_q;
      rgb_d   = de1_q ? rgb1_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0; v_q <= '0; fc_q <= '0; mode_q <= '0; solid_q <= '0; fs0_q <= 1'b0;
         de1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; fs1_q <= 1'b0; rgb1_q <= '0;
         de_q <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0; fs_q <= 1'b0; rgb_q <= '0;
      end else begin
         h_q <= h_d; v_q <= v_d; fc_q <= fc_d; mode_q <= mode_d; solid_q <= solid_d; fs0_q <= fs0_d;
         de1_q <= de1_d; hs1_q <= hs1_d; vs1_q <= vs1_d; fs1_q <= fs1_d; rgb1_q <= rgb1_d;
         de_q <= de_d; hs_q <= hs_d; vs_q <= vs_d; fs_q <= fs_d; rgb_q <= rgb_d;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign de          = de_q;
   assign frame_start = fs_q;
   assign active_mode = mode_q;
   assign rgb_r       = rgb_q[3*DATA_W-1:2*DATA_W];
   assign rgb_g       = rgb_q[2*DATA_W-1:DATA_W];
   assign rgb_b       = rgb_q[DATA_W-1:0];
endmodule

// File: tb/tb_mv_pattern_gen.sv
// tb_mv_pattern_gen: self-checking bench for mv_pattern_gen against a frame-arithmetic model.
module tb_mv_pattern_gen;
   localparam int AF   = 2;
   localparam int MAXE = 4096;

   typedef struct {
      int          tsel;
      logic [2:0]  m;
      int          x;
      int          y;
      logic [23:0] rgb;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic        auto_cycle = 1'b0;
   logic [23:0] solid_rgb = 24'h0;
   logic        positive_hsync = 1'b1, positive_vsync = 1'b1;
   logic [15:0] htotal_size, hactive_start, hactive_end, hsync_start, hsync_end;
   logic [15:0] vtotal_size, vactive_start, vactive_end, vsync_start, vsync_end;
   logic        hs, vs, de, frame_start;
   logic [7:0]  rgb_r, rgb_g, rgb_b;
   logic [2:0]  active_mode;

   int          n_chk = 0, n_fail = 0, k = 0, rnd_rate = 0;
   bit          auto_sc = 1'b0;
   logic [2:0]  mode_at [MAXE];
   logic [23:0] solid_at [MAXE];
   logic [23:0] cap [8][80];
   logic [23:0] bar_col [8];
   vec_t        tbl [20];
   logic [2:0]  seq [13];

   always #5 clk = ~clk;

   mv_pattern_gen #(.DATA_W(8), .CHK_LOG2(5), .AUTO_FRAMES(AF)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .auto_cycle(auto_cycle), .solid_rgb(solid_rgb),
      .positive_hsync(positive_hsync), .positive_vsync(positive_vsync),
      .htotal_size(htotal_size), .hactive_start(hactive_start), .hactive_end(hactive_end),
      .hsync_start(hsync_start), .hsync_end(hsync_end),
      .vtotal_size(vtotal_size), .vactive_start(vactive_start), .vactive_end(vactive_end),
      .vsync_start(vsync_start), .vsync_end(vsync_end),
      .hs(hs), .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
      .active_mode(active_mode), .frame_start(frame_start));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
      end
   endtask

   function automatic bit is_deg();
      return (int'(htotal_size) < 2) || (int'(vtotal_size) < 2);
   endfunction

   function automatic int fl();
      return int'(htotal_size) * int'(vtotal_size);
   endfunction

   function automatic logic [2:0] fmode(input int f);
      if (f == 0) return 3'd0;
      if (auto_sc) return 3'((f / AF) % 6);
      return (mode_at[f * fl()] > 3'd5) ? 3'd0 : mode_at[f * fl()];
   endfunction

   function automatic logic [23:0] fsolid(input int f);
      return (f == 0) ? 24'h0 : solid_at[f * fl()];
   endfunction

   function automatic logic [23:0] pix(input logic [2:0] m, input logic [23:0] sol,
                                      input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] hact, input logic [15:0] vact);
      int w, idx;
      case (m)
         3'd0: begin
            w = int'(hact) / 8;
            idx = (w == 0) ? 7 : int'(x) / w;
            if (idx > 7) idx = 7;
            return bar_col[idx];
         end
         3'd1: return {3{x[7:0]}};
         3'd2: return {3{y[7:0]}};
         3'd3: return (((int'(x) / 32) + (int'(y) / 32)) % 2 == 1) ? 24'h0 : 24'hFFFFFF;
         3'd4: return sol;
         3'd5: return (x == 0 || x == hact - 16'd1 || y == 0 || y == vact - 16'd1) ? 24'hFFFFFF : 24'h0;
         default: return 24'h0;
      endcase
   endfunction

   // Output after edge k shows counter position k-2; frame f starts at position f*fl().
   task automatic check_cycle();
      int p, h, v, f, fk;
      logic ehs, evs, ede, efs;
      logic [23:0] ergb;
      logic [15:0] x, y;
      h = 0; v = 0; f = 0; p = 0;
      if (k >= 2 && !is_deg()) begin
         p = k - 2;
         h = p % int'(htotal_size);
         v = (p / int'(htotal_size)) % int'(vtotal_size);
         f = p / fl();
      end
      x = 16'(h - int'(hactive_start));
      y = 16'(v - int'(vactive_start));
      ede = (k >= 2) && !is_deg() && h >= int'(hactive_start) && h < int'(hactive_end)
            && v >= int'(vactive_start) && v < int'(vactive_end);
      ehs = (k >= 2) && (((h >= int'(hsync_start)) && (h < int'(hsync_end))) == positive_hsync);
      evs = (k >= 2) && (((v >= int'(vsync_start)) && (v < int'(vsync_end))) == positive_vsync);
      efs = (k >= 2) && !is_deg() && p > 0 && (p % fl() == 0);
      ergb = ede ? pix(fmode(f), fsolid(f), x, y, hactive_end - hactive_start,
                       vactive_end - vactive_start) : 24'h0;
      fk = is_deg() ? 0 : k / fl();
      chk("de", 32'(de), 32'(ede));
      chk("hs", 32'(hs), 32'(ehs));
      chk("vs", 32'(vs), 32'(evs));
      chk("frame_start", 32'(frame_start), 32'(efs));
      chk("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(ergb));
      chk("active_mode", 32'(active_mode), 32'(fmode(fk)));
      if (ede && f >= 1 && y < 8 && x < 80) cap[y][x] = {rgb_r, rgb_g, rgb_b};
   endtask

   task automatic start(input logic [2:0] m, input bit au, input int tsel,
                        input bit ph, input bit pv, input int rate);
      rst_n = 1'b0;
      mode = m; auto_cycle = au; auto_sc = au; rnd_rate = rate;
      positive_hsync = ph; positive_vsync = pv;
      htotal_size = (tsel == 1) ? 16'd80 : (tsel == 2) ? 16'd1 : 16'd20;
      hactive_start = 16'd4;
      hactive_end = (tsel == 1) ? 16'd68 : 16'd20;
      hsync_start = 16'd0; hsync_end = 16'd2;
      vtotal_size = 16'd6; vactive_start = 16'd2; vactive_end = 16'd6;
      vsync_start = 16'd0; vsync_end = 16'd1;
      repeat (2) @(negedge clk);
      k = 0;
      check_cycle();
      mode_at[0] = mode; solid_at[0] = solid_rgb;
      rst_n = 1'b1;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         if (k + 1 >= MAXE) begin
            $display("FAIL edge_budget k=%0d actual=%0d required=<%0d", k, k + 1, MAXE);
            $fatal(1, "edge budget exceeded");
         end
         if (rnd_rate > 0 && $urandom_range(rnd_rate - 1) == 0) begin
            mode = 3'($urandom_range(7));
            solid_rgb = 24'($urandom);
         end
         mode_at[k + 1] = mode; solid_at[k + 1] = solid_rgb;
         @(posedge clk);
         k++;
         #1;
         check_cycle();
      end
   endtask

   initial begin
      int nde, nhs, nvs;
      bar_col = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      seq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
      tbl = '{
         '{0, 3'd0, 0, 0, 24'hFFFFFF}, '{0, 3'd0, 3, 1, 24'hFFFF00},
         '{0, 3'd0, 4, 2, 24'h00FFFF}, '{0, 3'd0, 7, 0, 24'h00FF00},
         '{0, 3'd0, 8, 3, 24'hFF00FF}, '{0, 3'd0, 11, 0, 24'hFF0000},
         '{0, 3'd0, 12, 1, 24'h0000FF}, '{0, 3'd0, 15, 3, 24'h000000},
         '{0, 3'd2, 5, 3, 24'h030303},
         '{1, 3'd1, 0, 0, 24'h000000}, '{1, 3'd1, 63, 2, 24'h3F3F3F},
         '{1, 3'd1, 17, 1, 24'h111111},
         '{1, 3'd3, 31, 0, 24'hFFFFFF}, '{1, 3'd3, 32, 0, 24'h000000},
         '{1, 3'd3, 63, 3, 24'h000000},
         '{1, 3'd5, 0, 1, 24'hFFFFFF}, '{1, 3'd5, 63, 2, 24'hFFFFFF},
         '{1, 3'd5, 10, 0, 24'hFFFFFF}, '{1, 3'd5, 10, 3, 24'hFFFFFF},
         '{1, 3'd5, 10, 2, 24'h000000}};

      // Pattern probes: run each (timing, mode) for two frames, then compare captured pixels
      for (int i = 0; i < 20; i++) begin
         if (i == 0 || tbl[i].tsel != tbl[i-1].tsel || tbl[i].m != tbl[i-1].m) begin
            start(tbl[i].m, 1'b0, tbl[i].tsel, 1'b1, 1'b1, 0);
            step(2 * fl() + 4);
         end
         chk($sformatf("tbl%0d", i), 32'(cap[tbl[i].y][tbl[i].x]), 32'(tbl[i].rgb));
      end

      // Negative polarity and per-frame de/sync counts
      start(3'd0, 1'b0, 0, 1'b0, 1'b0, 0);
      step(2);
      nde = 0; nhs = 0; nvs = 0;
      for (int i = 0; i < 120; i++) begin
         step(1);
         nde += int'(de); nhs += int'(!hs); nvs += int'(!vs);
      end
      chk("de_per_frame", 32'(nde), 32'd64);
      chk("hs_low_per_frame", 32'(nhs), 32'd12);
      chk("vs_low_per_frame", 32'(nvs), 32'd20);

      // Mid-frame mode change to solid colour
      start(3'd0, 1'b0, 0, 1'b1, 1'b1, 0);
      step(60);
      mode = 3'd4; solid_rgb = 24'h123456;
      step(46);
      chk("tear_free", 32'({rgb_r, rgb_g, rgb_b}), 32'hFFFFFF);
      step(14);
      chk("mode_after_bnd", 32'(active_mode), 32'd4);
      step(46);
      chk("solid_next_frame", 32'({rgb_r, rgb_g, rgb_b}), 32'h123456);
      step(120);

      // Random mode/colour/polarity traffic
      start(3'($urandom_range(7)), 1'b0, 0, 1'($urandom), 1'($urandom), 40);
      step(960);

      // Auto-cycle ignores mode input and steps every AF frames
      start(3'd3, 1'b1, 0, 1'b1, 1'b1, 30);
      for (int f = 0; f < 13; f++) begin
         step(f * 120 + 1 - k);
         chk($sformatf("auto_seq%0d", f), 32'(active_mode), 32'(seq[f]));
      end

      // Asynchronous reset mid-line while the picture is active
      start(3'd0, 1'b0, 0, 1'b1, 1'b1, 0);
      step(50);
      chk("pre_reset_de", 32'(de), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", 32'({hs, vs, de, frame_start, active_mode, rgb_r, rgb_g, rgb_b} != 0), 32'd0);

      // Degenerate horizontal total
      start(3'd0, 1'b0, 2, 1'b1, 1'b1, 0);
      step(60);
      chk("degen_no_x", 32'($isunknown({hs, vs, de, frame_start, active_mode, rgb_r, rgb_g, rgb_b})), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mv_pattern_gen.md
MV_PATTERN_GEN -- requirements
Module: mv_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per colour component (8, 10 or 12).
REQ-002 SHALL have parameter CHK_LOG2, default 5, checkerboard square size as log2 pixels.
REQ-003 SHALL have parameter AUTO_FRAMES, default 60, frames per pattern in auto-cycle mode (>=1).
REQ-004 SHALL have ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- mode  in  3  requested pattern, 0-5; values 6-7 select 0.
- auto_cycle  in  1  1 = ignore mode and step patterns automatically.
- solid_rgb  in  3*DATA_W  solid colour {r,g,b}.
- positive_hsync, positive_vsync  in  1 each  sync polarity, 1 = active-high.
- htotal_size, hactive_start, hactive_end, hsync_start, hsync_end  in  16 each  horizontal timing, in pixels.
- vtotal_size, vactive_start, vactive_end, vsync_start, vsync_end  in  16 each  vertical timing, in lines.
- hs, vs, de  out  1 each  video sync and data enable.
- rgb_r, rgb_g, rgb_b  out  DATA_W each  pixel data.
- active_mode  out  3  pattern currently displayed.
- frame_start  out  1  one-cycle pulse, aligned with the first output cycle of each frame.

Function
REQ-005 SHALL count h_cnt from 0 to htotal_size-1; wrap when h_cnt >= htotal_size-1. v_cnt SHALL step on h wrap and wrap when v_cnt >= vtotal_size-1. The >= compare means a mid-frame timing change cannot strand the counters.
REQ-006 SHALL derive de_raw = (hactive_start <= h_cnt < hactive_end) AND (vactive_start <= v_cnt < vactive_end).
REQ-007 SHALL assert the hsync window for hsync_start <= h_cnt < hsync_end and the vsync window for vsync_start <= v_cnt < vsync_end. The output level SHALL be the window value if positive_*sync = 1, otherwise its inverse.
REQ-008 SHALL compute x = h_cnt - hactive_start, y = v_cnt - vactive_start, hactive = hactive_end - hactive_start, vactive = vactive_end - vactive_start, all 16 bits unsigned.
REQ-009 SHALL update active_mode only at the frame boundary, defined as h_cnt = htotal_size-1 and v_cnt = vtotal_size-1. A mode change mid-frame SHALL therefore never tear the image.
REQ-010 At the frame boundary with auto_cycle = 0, active_mode SHALL take mode, with 6-7 mapped to 0.
REQ-011 With auto_cycle = 1, a frame counter SHALL count boundaries. When it reaches AUTO_FRAMES-1 it SHALL clear and active_mode SHALL step 0→1→...→5→0.
REQ-012 When auto_cycle falls to 0, the frame counter SHALL clear. When it rises, counting SHALL start from 0.
REQ-013 Pattern 0 SHALL be 8 vertical colour bars.
- Bar width w = hactive>>3; the bar index steps every w pixels of x and saturates at 7.
- Colour order: white, yellow, cyan, green, magenta, red, blue, black.
- Full-scale = all ones.
REQ-014 Pattern 1 SHALL be a horizontal ramp: r = g = b = x[DATA_W-1:0] (wraps).
REQ-015 Pattern 2 SHALL be a vertical ramp: r = g = b = y[DATA_W-1:0].
REQ-016 Pattern 3 SHALL be a checkerboard: white when bit CHK_LOG2 of x XOR bit CHK_LOG2 of y = 0, else black.
REQ-017 Pattern 4 SHALL output solid_rgb, sampled at the frame boundary and held for the frame.
REQ-018 Pattern 5 SHALL output a white 1-pixel border on black: x = 0, x = hactive-1, y = 0 or y = vactive-1.
REQ-019 SHALL output rgb = 0 whenever the delayed de is 0.
REQ-020 SHALL have a fixed latency of 2 clocks from counter state to hs/vs/de/rgb/frame_start. All of these SHALL be delayed equally, with identical alignment in every mode.
REQ-021 SHALL register all outputs; no combinational path from any input to any output.
REQ-022 If htotal_size < 2 or vtotal_size < 2, the counters SHALL hold at 0 and de SHALL be 0.

Reset
REQ-023 While rst_n = 0, the following SHALL be 0: h_cnt, v_cnt, the frame counter, active_mode, hs, vs, de, rgb, frame_start.
REQ-024 After rst_n deasserts, counting SHALL start from h_cnt = 0, v_cnt = 0 on the first clock edge. The first frame_start SHALL occur 2 clocks after the first frame boundary.
REQ-025 Asserting rst_n mid-frame SHALL clear all state immediately (asynchronously).

Verification
All scenarios use htotal 20, hactive 4..20, hsync 0..2, vtotal 6, vactive 2..6, vsync 0..1, DATA_W = 8, unless stated.
REQ-026 Reset, then mode = 0:
- de high 16 pixels per line on v = 2..5, 2-clock lag.
- Bars 2 pixels wide: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-027 Polarity: positive_hsync = 0, positive_vsync = 0 → hs low for exactly 2 clocks per line, vs low for exactly 20 clocks per frame, both delayed 2 clocks.
REQ-028 Mode change: switch mode 0→4 mid-frame with solid_rgb = 123456 → rest of frame unchanged. The next frame is all 123456 and active_mode = 4 after the boundary.
REQ-029 Auto-cycle: auto_cycle = 1, AUTO_FRAMES = 2 → active_mode sequence 0,0,1,1,2,2,3,3,4,4,5,5,0 over successive frames; one frame_start per frame.
REQ-030 Patterns 1/3/5 with hactive 64, CHK_LOG2 = 5:
- Pattern 1: ramp 00..3F across each line.
- Pattern 3: checker flips at x = 32.
- Pattern 5: border pixels FFFFFF, interior 000000.
REQ-031 Reset and degenerate timing:
- Assert rst_n = 0 mid-line → all outputs 0 asynchronously.
- htotal_size = 1 → de stays 0, no X on any output.
